// File: rtl/link_mon_pkg.sv
// Shared definitions for the link status monitor: FSM state encoding and
// parameter defaults.
package link_mon_pkg;

  localparam int unsigned QUAL_CYCLES_DEF   = 1024;
  localparam int unsigned GLITCH_CYCLES_DEF = 4;
  localparam int unsigned CNT_BITS_DEF      = 16;

  typedef enum logic [1:0] {
    ST_DOWN    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_UP      = 2'd2,
    ST_DROPOUT = 2'd3
  } link_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter. A synchronous clear beats a coincident increment,
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Clear has priority; increment only below the saturation value.
  always_ff @(posedge clock_i) begin
    if (reset_i || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/link_status_monitor.sv
// Link status monitor: qualifies the combined link/clock status before
// declaring the link ready, tolerates short dropouts while up, and counts
// declared losses and tolerated dropouts.
// Optional feature: define LINK_MON_GLITCH_CNT_EN to build the dropout
// counter; otherwise glitch_cnt_o is tied to zero.
module link_status_monitor
  import link_mon_pkg::*;
#(
  parameter int unsigned QUAL_CYCLES   = QUAL_CYCLES_DEF,
  parameter int unsigned GLITCH_CYCLES = GLITCH_CYCLES_DEF,
  parameter int unsigned CNT_BITS      = CNT_BITS_DEF
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                mmcms_locked_i,
  input  logic                gbt_rxready_i,
  input  logic                gbt_rxvalid_i,
  input  logic                gbt_txready_i,
  input  logic                cnt_reset_i,
  output logic                link_ready_o,
  output logic                link_lost_o,
  output logic [CNT_BITS-1:0] unlock_cnt_o,
  output logic [CNT_BITS-1:0] glitch_cnt_o,
  output logic [1:0]          state_o
);

  localparam int unsigned QUAL_W = $clog2(QUAL_CYCLES + 1);
  localparam int unsigned BAD_W  = (GLITCH_CYCLES == 0) ? 1 : $clog2(GLITCH_CYCLES + 1);
  localparam logic [QUAL_W-1:0] QUAL_LAST = QUAL_W'(QUAL_CYCLES - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(GLITCH_CYCLES);

  link_state_t       state;
  logic [QUAL_W-1:0] qual_cnt;
  logic [BAD_W-1:0]  bad_cnt;
  logic              good;
  logic              lose_now;

  assign good    = mmcms_locked_i & gbt_rxready_i & gbt_rxvalid_i & gbt_txready_i;
  assign state_o = state;

  // Loss is declared when a dropout outlives its budget, or on the first bad
  // cycle in UP when no dropout budget exists.
  always_comb begin
    lose_now = 1'b0;
    if (!good) begin
      if (state == ST_DROPOUT && bad_cnt >= BAD_LAST) begin
        lose_now = 1'b1;
      end else if (GLITCH_CYCLES == 0 && state == ST_UP) begin
        lose_now = 1'b1;
      end
    end
  end

  // Link FSM with registered ready level and loss strobe; ready follows the
  // state register one cycle later.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state        <= ST_DOWN;
      qual_cnt     <= '0;
      bad_cnt      <= '0;
      link_ready_o <= 1'b0;
      link_lost_o  <= 1'b0;
    end else begin
      link_ready_o <= (state == ST_UP) || (state == ST_DROPOUT);
      link_lost_o  <= lose_now;
      case (state)
        ST_DOWN: begin
          if (good) begin
            state    <= ST_QUALIFY;
            qual_cnt <= QUAL_W'(1);
          end
        end
        ST_QUALIFY: begin
          if (!good) begin
            state    <= ST_DOWN;
            qual_cnt <= '0;
          end else if (qual_cnt >= QUAL_LAST) begin
            state    <= ST_UP;
            qual_cnt <= '0;
          end else begin
            qual_cnt <= qual_cnt + 1'b1;
          end
        end
        ST_UP: begin
          if (lose_now) begin
            state <= ST_DOWN;
          end else if (!good) begin
            state   <= ST_DROPOUT;
            bad_cnt <= BAD_W'(1);
          end
        end
        ST_DROPOUT: begin
          if (good) begin
            state   <= ST_UP;
            bad_cnt <= '0;
          end else if (lose_now) begin
            state   <= ST_DOWN;
            bad_cnt <= '0;
          end else begin
            bad_cnt <= bad_cnt + 1'b1;
          end
        end
        default: state <= ST_DOWN;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_BITS)) u_unlock_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clr     (cnt_reset_i),
    .inc     (lose_now),
    .count   (unlock_cnt_o)
  );

`ifdef LINK_MON_GLITCH_CNT_EN
  logic glitch_end;

  // A dropout that recovers before its budget runs out counts as a glitch.
  always_comb begin
    glitch_end = (state == ST_DROPOUT) && good;
  end

  sat_counter #(.WIDTH(CNT_BITS)) u_glitch_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clr     (cnt_reset_i),
    .inc     (glitch_end),
    .count   (glitch_cnt_o)
  );
`else
  assign glitch_cnt_o = '0;
`endif

endmodule
